// File: rtl/msx_bus_pkg.sv
// Shared state encoding, open-bus value and strobe helper for the MSX bus cycle controller.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package msx_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ACCESS,
    HOLD,
    IGNORE
  } msx_state_t;

  // Value presented on the data bus when no device supplies read data.
  localparam logic [7:0] MSX_OPEN_BUS = 8'hFF;

  // Exactly one of RD/WR active marks a bus access; both low is a glitch, not a cycle.
  function automatic logic msx_strobe(input logic rd_n, input logic wr_n);
    return (!rd_n) ^ (!wr_n);
  endfunction

endpackage

// File: rtl/msx_prio_enc.sv
// Fixed-priority one-hot encoder: the lowest set request bit wins, found flags any request.
// Latency: combinational.
// Backpressure: none.
module msx_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         found
);

  // Scan from bit 0 upward and keep only the first request seen.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msx_bus_cycle_ctrl.sv
// MSX cartridge bus cycle sequencer: detects a cycle, grants one device, returns its read data.
// Latency: REQ_* one edge after the strobe, grant one edge later, data/WAIT release on the ack edge.
// Backpressure: WAIT_n holds the CPU until the device acks or times out (macro MSX_BUS_WAIT_EN).
module msx_bus_cycle_ctrl
  import msx_bus_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                   CLK,
  input  logic                   RESET_n,
  input  logic                   BUS_RESET_n,
  input  logic [15:0]            BUS_ADDR,
  input  logic [7:0]             BUS_DIN,
  input  logic                   BUS_RD_n,
  input  logic                   BUS_WR_n,
  input  logic                   BUS_MERQ_n,
  input  logic                   BUS_IORQ_n,
  input  logic                   BUS_SLTSL_n,
  input  logic                   BUS_M1_n,
  output logic [7:0]             BUS_DOUT,
  output logic                   BUS_BUSDIR_n,
  output logic                   BUS_WAIT_n,
  input  logic [NUM_DEV-1:0]     DEV_SEL,
  input  logic [NUM_DEV-1:0]     DEV_ACK,
  input  logic [8*NUM_DEV-1:0]   DEV_RDATA,
  output logic [15:0]            REQ_ADDR,
  output logic [7:0]             REQ_WDATA,
  output logic                   REQ_WR,
  output logic                   REQ_IO,
  output logic [NUM_DEV-1:0]     REQ_GNT,
  output logic                   TIMEOUT_ERR
);

  if (NUM_DEV < 1 || NUM_DEV > 8 || TIMEOUT < 1) begin : g_param_check
    $error("msx_bus_cycle_ctrl: NUM_DEV must be 1..8 and TIMEOUT at least 1");
  end

  msx_state_t         state, state_nxt;
  logic               strobe, strobe_q;
  logic               mem_cyc, io_cyc, cyc_start;
  logic [NUM_DEV-1:0] enc_gnt, gnt_nxt;
  logic               enc_found;
  logic               acked;
  logic [7:0]         ack_rdata, dout_nxt;
  logic               busdir_n_nxt;
  logic               latch_req;

  // Interrupt-acknowledge (IORQ with M1 low) is deliberately not an I/O cycle.
  assign strobe    = msx_strobe(BUS_RD_n, BUS_WR_n);
  assign mem_cyc   = !BUS_MERQ_n && !BUS_SLTSL_n;
  assign io_cyc    = !BUS_IORQ_n && BUS_M1_n;
  assign cyc_start = strobe && !strobe_q && (mem_cyc || io_cyc);

  msx_prio_enc #(.N(NUM_DEV)) u_prio_enc (
    .req   (DEV_SEL),
    .gnt   (enc_gnt),
    .found (enc_found)
  );

  // Only the granted device's ack and read byte are visible; the grant is one-hot so an OR-mux suffices.
  assign acked = |(DEV_ACK & REQ_GNT);
  always_comb begin
    ack_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (REQ_GNT[i]) ack_rdata = ack_rdata | DEV_RDATA[8*i +: 8];
    end
  end

`ifdef MSX_BUS_WAIT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             timed_out;
  logic             to_fire;

  // The edge that would bring the counter to TIMEOUT is the one that gives up on the device.
  assign timed_out = (to_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // Next state and next registered outputs; a bus reset overrides everything at the end.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = REQ_GNT;
    dout_nxt  = BUS_DOUT;
    latch_req = 1'b0;
`ifdef MSX_BUS_WAIT_EN
    to_fire   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cyc_start) begin
          state_nxt = DECODE;
          latch_req = 1'b1;
        end
      end
      DECODE: begin
        if (enc_found) begin
          state_nxt = ACCESS;
          gnt_nxt   = enc_gnt;
        end else begin
          state_nxt = IGNORE;
        end
      end
      ACCESS: begin
        if (!strobe) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (acked) begin
          state_nxt = HOLD;
          gnt_nxt   = '0;
          dout_nxt  = ack_rdata;
        end
`ifdef MSX_BUS_WAIT_EN
        else if (timed_out) begin
          state_nxt = HOLD;
          gnt_nxt   = '0;
          dout_nxt  = MSX_OPEN_BUS;
          to_fire   = 1'b1;
        end
`endif
      end
      HOLD, IGNORE: begin
        if (!strobe) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!BUS_RESET_n) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      dout_nxt  = MSX_OPEN_BUS;
      latch_req = 1'b0;
`ifdef MSX_BUS_WAIT_EN
      to_fire   = 1'b0;
`endif
    end
    busdir_n_nxt = !((state_nxt == HOLD) && !REQ_WR);
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Strobe history, grant, read data, bus direction and latched cycle attributes.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      strobe_q     <= 1'b0;
      REQ_GNT      <= '0;
      BUS_DOUT     <= MSX_OPEN_BUS;
      BUS_BUSDIR_n <= 1'b1;
      REQ_ADDR     <= '0;
      REQ_WDATA    <= '0;
      REQ_WR       <= 1'b0;
      REQ_IO       <= 1'b0;
    end else begin
      strobe_q     <= strobe;
      REQ_GNT      <= gnt_nxt;
      BUS_DOUT     <= dout_nxt;
      BUS_BUSDIR_n <= busdir_n_nxt;
      if (!BUS_RESET_n) begin
        REQ_ADDR  <= '0;
        REQ_WDATA <= '0;
        REQ_WR    <= 1'b0;
        REQ_IO    <= 1'b0;
      end else if (latch_req) begin
        REQ_ADDR  <= BUS_ADDR;
        REQ_WDATA <= BUS_DIN;
        REQ_WR    <= !BUS_WR_n;
        REQ_IO    <= !mem_cyc;
      end
    end
  end

`ifdef MSX_BUS_WAIT_EN
  // Wait counter restarts whenever ACCESS is not active and saturates rather than wrapping.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)                       to_cnt <= '0;
    else if (state != ACCESS)           to_cnt <= '0;
    else if (to_cnt != CNT_W'(TIMEOUT)) to_cnt <= to_cnt + CNT_W'(1);
  end

  // WAIT follows the ACCESS state; the timeout error is a single-cycle pulse.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      BUS_WAIT_n  <= 1'b1;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      BUS_WAIT_n  <= (state_nxt != ACCESS);
      TIMEOUT_ERR <= to_fire;
    end
  end
`else
  assign BUS_WAIT_n  = 1'b1;
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule
